// File: rtl/rr_rht_ctrl_pkg.sv
// Shared constants and types for the rename-history-table controller.
// Defines RHT geometry (group width, depth, id width) and the walk FSM states.
package RR_pkg;

   localparam int INSTR_COUNT = 2;
   localparam int C_NUM       = 4;
   localparam int K           = 4;
   localparam int D           = C_NUM * K;
   localparam int RW          = $clog2(D);

   typedef logic [RW-1:0] rht_id_t;

   typedef enum logic {
      IDLE,
      WALK
   } rr_rht_state_e;

endpackage

// File: rtl/rr_ptr_wrap.sv
// Combinational modular add/sub of an RHT pointer by a count (0..D).
// Ports: ptr (pointer), amt (amount), sub (1=subtract), res (result mod D).
module rr_ptr_wrap #(
   parameter int D  = 16,
   parameter int RW = $clog2(D)
) (
   input  logic [RW-1:0] ptr,
   input  logic [RW:0]   amt,
   input  logic          sub,
   output logic [RW-1:0] res
);

   localparam logic [RW+1:0] DW = (RW+2)'(D);

   logic [RW+1:0] tmp;

   // D need not be a power of two, so the wrap is an explicit compare.
   always_comb begin
      tmp = '0;
      if (sub) begin
         if ({1'b0, ptr} >= amt)
            tmp = {2'b00, ptr} - {1'b0, amt};
         else
            tmp = {2'b00, ptr} + DW - {1'b0, amt};
      end else begin
         tmp = {2'b00, ptr} + {1'b0, amt};
         if (tmp >= DW)
            tmp = tmp - DW;
      end
      res = RW'(tmp);
   end

endmodule

// File: rtl/rr_rht_ctrl.sv
// RHT controller: allocates entries per rename group, retires on commit, and
// walks youngest-first back to a recovery point, one entry per cycle.
// Ports: clk/rst, l_dst_valid/stall/alloc_fire/alloc_rht_id (allocate),
// commit_en (retire mask), rec_en/rec_rht_id/rec_busy (recovery),
// walk_en/walk_rht_id (undo stream), rht_count (occupancy).
module rr_rht_ctrl #(
   parameter int INSTR_COUNT = RR_pkg::INSTR_COUNT,
   parameter int C_NUM       = RR_pkg::C_NUM,
   parameter int K           = RR_pkg::K,
   parameter int D           = C_NUM * K,
   parameter int RW          = $clog2(D)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             l_dst_valid,
   output logic                             stall,
   output logic                             alloc_fire,
   output logic [INSTR_COUNT-1:0][RW-1:0]   alloc_rht_id,
   input  logic [INSTR_COUNT-1:0]           commit_en,
   input  logic                             rec_en,
   input  logic [RW-1:0]                    rec_rht_id,
   output logic                             rec_busy,
   output logic                             walk_en,
   output logic [RW-1:0]                    walk_rht_id,
   output logic [RW:0]                      rht_count
);

   import RR_pkg::*;

   localparam logic [RW:0] IC_W = (RW+1)'(INSTR_COUNT);
   localparam logic [RW:0] D_W  = (RW+1)'(D);
   localparam logic [RW:0] ONE  = (RW+1)'(1);

   rr_rht_state_e state, state_next;

   logic [RW-1:0] head, tail;
   logic [RW:0]   count, walk_left;
   logic [RW:0]   ncommit, free;
   logic [RW-1:0] head_add, tail_add, tail_m1, n_rec;

   always_comb begin
      ncommit = '0;
      for (int i = 0; i < INSTR_COUNT; i++)
         ncommit = ncommit + (RW+1)'(commit_en[i]);
   end

   rr_ptr_wrap #(.D(D), .RW(RW)) u_head (
      .ptr(head), .amt(ncommit), .sub(1'b0), .res(head_add)
   );

   rr_ptr_wrap #(.D(D), .RW(RW)) u_tail_inc (
      .ptr(tail), .amt(IC_W), .sub(1'b0), .res(tail_add)
   );

   rr_ptr_wrap #(.D(D), .RW(RW)) u_tail_dec (
      .ptr(tail), .amt(ONE), .sub(1'b1), .res(tail_m1)
   );

   // Entries younger than the recovery point: (tail-1) - rec_rht_id.
   rr_ptr_wrap #(.D(D), .RW(RW)) u_nrec (
      .ptr(tail_m1), .amt({1'b0, rec_rht_id}), .sub(1'b1), .res(n_rec)
   );

   for (genvar g = 0; g < INSTR_COUNT; g++) begin : g_id
      rr_ptr_wrap #(.D(D), .RW(RW)) u_id (
         .ptr(tail), .amt((RW+1)'(g)), .sub(1'b0),
         .res(alloc_rht_id[g])
      );
   end

   assign free = D_W - count;

   always_comb begin
      state_next  = state;
      walk_en     = (state == WALK);
      rec_busy    = walk_en;
      walk_rht_id = walk_en ? tail_m1 : '0;
      rht_count   = count;
      stall       = rst || rec_en || walk_en || (free < IC_W);
      alloc_fire  = l_dst_valid && !stall;
      unique case (1'b1)
         (state == IDLE): if (rec_en && n_rec != '0) state_next = WALK;
         (state == WALK): if (walk_left == ONE) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         head      <= '0;
         tail      <= '0;
         count     <= '0;
         walk_left <= '0;
      end else begin
         state <= state_next;
         head  <= head_add;
         count <= count + (alloc_fire ? IC_W : '0) - ncommit
                  - (walk_en ? ONE : '0);
         if (walk_en)
            tail <= tail_m1;
         else if (alloc_fire)
            tail <= tail_add;
         if (walk_en)
            walk_left <= walk_left - ONE;
         else if (rec_en && n_rec != '0)
            walk_left <= {1'b0, n_rec};
      end
   end

endmodule

// File: tb/tb_rr_rht_ctrl.sv
// Self-checking bench for rr_rht_ctrl: directed scenarios plus random traffic
// checked every cycle against a queue-based occupancy model.
module tb_rr_rht_ctrl;

   localparam int IC = 2;
   localparam int D  = 16;
   localparam int RW = 4;

   logic                    clk = 0;
   logic                    rst = 1;
   logic                    l_dst_valid = 0;
   logic                    rec_en = 0;
   logic [IC-1:0]           commit_en = '0;
   logic [RW-1:0]           rec_rht_id = '0;
   logic                    stall, alloc_fire, rec_busy, walk_en;
   logic [IC-1:0][RW-1:0]   alloc_rht_id;
   logic [RW-1:0]           walk_rht_id;
   logic [RW:0]             rht_count;

   rr_rht_ctrl #(.INSTR_COUNT(IC), .C_NUM(4), .K(4)) dut (
      .clk(clk), .rst(rst), .l_dst_valid(l_dst_valid), .stall(stall),
      .alloc_fire(alloc_fire), .alloc_rht_id(alloc_rht_id),
      .commit_en(commit_en), .rec_en(rec_en), .rec_rht_id(rec_rht_id),
      .rec_busy(rec_busy), .walk_en(walk_en), .walk_rht_id(walk_rht_id),
      .rht_count(rht_count)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Model: occupied ids oldest-first, next alloc id, walk steps remaining.
   int occ[$];
   int mtail = 0;
   int wleft = 0;
   bit exp_stall_q = 1;

   task automatic chk(input string nm, input logic [31:0] act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   bit m_es, m_fire;
   int m_idx, m_n;

   always @(negedge clk) begin
      m_es   = rst || rec_en || (wleft > 0) || (D - occ.size() < IC);
      m_fire = l_dst_valid && !m_es;
      chk("stall", stall, m_es);
      chk("alloc_fire", alloc_fire, m_fire);
      for (int i = 0; i < IC; i++)
         chk("alloc_rht_id", alloc_rht_id[i], (mtail + i) % D);
      chk("rht_count", rht_count, occ.size());
      chk("rec_busy", rec_busy, wleft > 0);
      chk("walk_en", walk_en, wleft > 0);
      if (wleft > 0 && occ.size() > 0)
         chk("walk_rht_id", walk_rht_id, occ[$]);
      exp_stall_q = m_es;
      if (rst) begin
         occ.delete();
         mtail = 0;
         wleft = 0;
      end else begin
         m_n = 0;
         if (rec_en && wleft == 0) begin
            m_idx = -1;
            foreach (occ[j]) if (occ[j] == int'(rec_rht_id)) m_idx = j;
            if (m_idx >= 0) m_n = occ.size() - 1 - m_idx;
         end
         for (int c = 0; c < $countones(commit_en); c++)
            if (occ.size() > 0) void'(occ.pop_front());
         if (wleft > 0) begin
            if (occ.size() > 0) void'(occ.pop_back());
            mtail = (mtail + D - 1) % D;
            wleft--;
         end
         if (m_fire) begin
            for (int i = 0; i < IC; i++) occ.push_back((mtail + i) % D);
            mtail = (mtail + IC) % D;
         end
         if (m_n > 0) wleft = m_n;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic setup3();
      rst = 1;
      tick();
      rst = 0;
      l_dst_valid = 1;
      repeat (3) tick();
      l_dst_valid = 0;
   endtask

   int r_idx, r_nn, r_lim, r_nc;

   initial begin
      // Reset state
      tick();
      tick();
      rst = 0;
      #1;
      chk("rst_count", rht_count, 0);
      chk("rst_stall", stall, 0);
      chk("rst_id0", alloc_rht_id[0], 0);
      chk("rst_id1", alloc_rht_id[1], 1);
      chk("rst_busy", rec_busy, 0);
      chk("rst_walk_en", walk_en, 0);
      chk("rst_walk_id", walk_rht_id, 0);

      // First group
      l_dst_valid = 1;
      #1;
      chk("g1_stall", stall, 0);
      chk("g1_id0", alloc_rht_id[0], 0);
      chk("g1_id1", alloc_rht_id[1], 1);
      tick();
      l_dst_valid = 0;
      #1;
      chk("g1_count", rht_count, 2);

      // Fill to capacity, then free one slot at a time
      l_dst_valid = 1;
      repeat (7) tick();
      l_dst_valid = 0;
      #1;
      chk("full_count", rht_count, 16);
      chk("full_stall", stall, 1);
      commit_en = 2'b01;
      tick();
      commit_en = 0;
      #1;
      chk("c1_count", rht_count, 15);
      chk("c1_stall", stall, 1);
      commit_en = 2'b01;
      tick();
      commit_en = 0;
      #1;
      chk("c2_count", rht_count, 14);
      chk("c2_stall", stall, 0);

      // Wrap around the end of the table
      rst = 1;
      tick();
      rst = 0;
      l_dst_valid = 1;
      repeat (7) tick();
      l_dst_valid = 0;
      commit_en = 2'b11;
      repeat (7) tick();
      commit_en = 0;
      #1;
      chk("wrap_empty", rht_count, 0);
      l_dst_valid = 1;
      #1;
      chk("wrap_a0", alloc_rht_id[0], 14);
      chk("wrap_a1", alloc_rht_id[1], 15);
      tick();
      #1;
      chk("wrap_b0", alloc_rht_id[0], 0);
      chk("wrap_b1", alloc_rht_id[1], 1);
      tick();
      l_dst_valid = 0;
      #1;
      chk("wrap_tail", alloc_rht_id[0], 2);

      // Recovery walk
      setup3();
      rec_en = 1;
      rec_rht_id = 2;
      #1;
      chk("rec_stall", stall, 1);
      tick();
      rec_en = 0;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("walk_busy", rec_busy, 1);
         chk("walk_id", walk_rht_id, 5 - k);
         tick();
      end
      #1;
      chk("post_busy", rec_busy, 0);
      chk("post_id0", alloc_rht_id[0], 3);
      chk("post_id1", alloc_rht_id[1], 4);
      chk("post_count", rht_count, 3);
      chk("post_stall", stall, 0);
      l_dst_valid = 1;
      tick();
      l_dst_valid = 0;

      // Walk with commits in the first walk cycle
      setup3();
      rec_en = 1;
      rec_rht_id = 2;
      tick();
      rec_en = 0;
      commit_en = 2'b11;
      tick();
      commit_en = 0;
      tick();
      tick();
      #1;
      chk("wc_count", rht_count, 1);
      chk("wc_busy", rec_busy, 0);

      // No-op recovery
      setup3();
      rec_en = 1;
      rec_rht_id = 5;
      #1;
      chk("nop_stall", stall, 1);
      tick();
      rec_en = 0;
      #1;
      chk("nop_busy", rec_busy, 0);
      chk("nop_stall2", stall, 0);
      chk("nop_tail", alloc_rht_id[0], 6);

      // Reset in the second walk cycle
      setup3();
      rec_en = 1;
      rec_rht_id = 2;
      tick();
      rec_en = 0;
      tick();
      rst = 1;
      #1;
      chk("mr_walk_id", walk_rht_id, 4);
      tick();
      rst = 0;
      #1;
      chk("mr_walk_en", walk_en, 0);
      chk("mr_count", rht_count, 0);
      chk("mr_busy", rec_busy, 0);
      chk("mr_id0", alloc_rht_id[0], 0);
      chk("mr_id1", alloc_rht_id[1], 1);
      chk("mr_walk_rid", walk_rht_id, 0);

      // Random traffic
      repeat (3000) begin
         rst = ($urandom_range(0, 299) == 0);
         if (!(l_dst_valid && exp_stall_q))
            l_dst_valid = $urandom_range(0, 1) == 1;
         rec_en = 0;
         r_nn = 0;
         if (wleft == 0 && occ.size() > 0 && $urandom_range(0, 9) == 0) begin
            r_idx = $urandom_range(0, occ.size() - 1);
            rec_rht_id = RW'(occ[r_idx]);
            rec_en = 1;
            r_nn = occ.size() - 1 - r_idx;
         end
         r_lim = occ.size() - ((wleft > r_nn) ? wleft : r_nn);
         if (r_lim > IC) r_lim = IC;
         if (r_lim < 0) r_lim = 0;
         r_nc = $urandom_range(0, r_lim);
         commit_en = IC'((1 << r_nc) - 1);
         tick();
      end

      rst = 0;
      l_dst_valid = 0;
      rec_en = 0;
      commit_en = 0;
      tick();
      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/rr_rht_ctrl.md
# rr_rht_ctrl

Rename-history-table (RHT) controller for the register-rename stage. It allocates RHT entries to each incoming rename group and retires them in order on commit. On a recovery request it sequences a youngest-first rollback walk: one RHT entry per cycle is driven to the rename datapath, which restores the map table and frees the physical register. It owns `stall` and `rec_busy` towards the front end.

## Interface
Parameters:
- `INSTR_COUNT`, 2: rename group width; every accepted group allocates exactly `INSTR_COUNT` entries.
- `C_NUM`, 4: checkpoint count factor.
- `K`, 4: entries per checkpoint; RHT depth `D = C_NUM*K`. `D` need not be a power of two.
- `RW = $clog2(D)`: RHT id width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `l_dst_valid` in 1: rename group valid; held stable while `stall` is high.
- `stall` out 1: group not accepted this cycle.
- `alloc_fire` out 1: `l_dst_valid && !stall`.
- `alloc_rht_id` out `INSTR_COUNT`x`RW`: ids for slots 0..`INSTR_COUNT`-1, equal to tail, tail+1, ... mod `D`.
- `commit_en` in `INSTR_COUNT`: thermometer-coded retire mask (contiguous from bit 0), oldest first.
- `rec_en` in 1: recovery request pulse.
- `rec_rht_id` in `RW`: RHT id of the offending instruction; it and all older entries survive.
- `rec_busy` out 1: walk in progress.
- `walk_en` out 1: undo one RHT entry this cycle.
- `walk_rht_id` out `RW`: entry to undo.
- `rht_count` out `RW+1`: occupied entries.

## Operation
- State: `head`, `tail` (`RW` bits), `count` (`RW+1` bits), FSM {IDLE, WALK}, `walk_left` (`RW+1` bits).
- Pointer increment wraps explicitly: `p+1 == D` gives 0; decrement at 0 gives `D-1`. Modular subtraction is done at `RW+1` bits with a conditional `+D`.
- `free = D - count`.
- `stall = rst || rec_en || (state==WALK) || (free < INSTR_COUNT)`. This is combinational.
- Alloc (on `alloc_fire`): `tail += INSTR_COUNT` (mod `D`).
- Commit: `ncommit = popcount(commit_en)`, `head += ncommit` (mod `D`). Commits are legal in any state, including WALK and the `rec_en` cycle.
- `count_next = count + (alloc_fire ? INSTR_COUNT : 0) - ncommit - (walk_en ? 1 : 0)`.
- IDLE with `rec_en`:
  - `N = (tail - rec_rht_id - 1) mod D`.
  - If `N == 0`, stay in IDLE.
  - Otherwise go to WALK with `walk_left = N`.
- WALK, every cycle:
  - `walk_en = 1`, `walk_rht_id = tail-1`.
  - `tail--` and `walk_left--`.
  - When `walk_left == 1`, return to IDLE.
- `rec_busy = (state == WALK)`. `walk_en` is 1 only in WALK.
- `rec_en` while in WALK is ignored; it is a bench-checked protocol violation.
- `rec_rht_id` must lie within the occupied range, i.e. `(rec_rht_id - head) mod D < count`.
- A `commit_en` mask that retires more entries than `count` is a protocol violation.
- Reset state: `head=tail=0`, `count=0`, IDLE, `walk_en=0`, `walk_rht_id=0`, `rec_busy=0`, `rht_count=0`, `alloc_rht_id={0,1,..}`.

## Timing
- Alloc: zero-cycle accept. `alloc_rht_id` is valid in the `alloc_fire` cycle; `tail` updates at the next edge.
- Commit: takes effect at the next edge. A commit can free space in cycle t so that `stall` drops in cycle t+1.
- Recovery with `rec_en` in cycle t and `N > 0`:
  - `rec_busy` and `walk_en` are high in cycles t+1..t+N.
  - `walk_rht_id` descends from old tail-1 to `rec_rht_id+1`.
  - In cycle t+N+1 the FSM is in IDLE with `tail = rec_rht_id+1`, and `stall` depends only on free space.
- Recovery with `N == 0`: `stall` is high only in cycle t; there is no busy cycle.
- Mid-operation `rst` (including during WALK): the next cycle is the reset state; the remaining walk is abandoned.

## Structure
- `RR_pkg` holds `INSTR_COUNT`, `C_NUM`, `K`, the derived `D` and `RW`, a `rht_id_t` typedef and an `rr_rht_state_e` enum {IDLE, WALK}.
- One sub-module, `rr_ptr_wrap`: a combinational modular add/sub of a pointer by a small constant or count. It is instantiated for head, tail, alloc ids and the `N` computation.
- The rest is a single always_ff block for state and pointers plus an always_comb block for outputs.

## Test plan
Defaults `D=16`, `INSTR_COUNT=2`.
- Reset, then `l_dst_valid=1` for one cycle → `stall=0`, `alloc_rht_id={0,1}`, `rht_count=2` next cycle.
- Fill:
  - 8 groups, no commit → `rht_count=16`, `stall=1`.
  - `commit_en=2'b01` → `rht_count=15`, `stall` stays 1.
  - Another `2'b01` → `rht_count=14`, `stall=0`.
- Wrap: with `head=tail=14` and count 0, two groups → ids `{14,15}` then `{0,1}`; `tail=2`.
- Walk: `tail=6`, `head=0`, `rec_en` with `rec_rht_id=2` →
  - `rec_busy` high for 3 cycles, `walk_rht_id` 5, 4, 3.
  - Then `tail=3`, and the next alloc gets `{3,4}`.
  - Repeat with `commit_en=2'b11` in the first walk cycle → `head=2`, final `rht_count=1`.
- No-op recovery: `rec_en` with `rec_rht_id=tail-1` → `stall` high for 1 cycle, `rec_busy` never high, `tail` unchanged.
- `rst` in the second walk cycle → next cycle all outputs at reset values, `walk_en=0`, `rht_count=0`.
